// File: rtl/riscv_uop_pkg.sv
// rtl/riscv_uop_pkg.sv - EX/MEM uop types, payload layout and load classifier
package riscv_uop_pkg;

    localparam int UOP_XLEN    = 32;
    localparam int UOP_RADDR_W = 5;

    // Memory operation carried by a uop into the MEM stage
    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    // Entry held at the EX->MEM boundary
    typedef struct packed {
        logic [UOP_XLEN-1:0]    alu_result;
        logic [UOP_XLEN-1:0]    store_data;
        logic [UOP_XLEN-1:0]    pc;
        logic [UOP_RADDR_W-1:0] rd_addr;
        logic                   rd_we;
        mem_op_t                mem_op;
    } ex_mem_payload_t;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        SK_EMPTY = 2'b00,
        SK_ONE   = 2'b01,
        SK_FULL  = 2'b10
    } skid_state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - valid/ready pipeline register, optional 2-entry skid (EX_MEM_SKID_EN)
module pipe_skid_buf
    import riscv_uop_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

`ifdef EX_MEM_SKID_EN

    skid_state_t  state;
    logic [W-1:0] head_q;
    logic [W-1:0] skid_q;
    logic         ready_q;
    logic         in_fire;
    logic         out_fire;

    // Ready comes straight from a flop so the upstream stage never sees a
    // combinational path from out_ready.
    assign in_ready  = ready_q;
    assign out_valid = (state == SK_ONE) || (state == SK_FULL);
    assign out_data  = head_q;
    assign in_fire   = in_valid & ready_q;
    assign out_fire  = out_valid & out_ready;

    // Occupancy FSM: head always holds the oldest entry, skid the younger one
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SK_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else if (flush) begin
            state   <= SK_EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                SK_EMPTY: begin
                    if (in_fire) begin
                        head_q <= in_data;
                        state  <= SK_ONE;
                    end
                end
                SK_ONE: begin
                    if (in_fire && out_fire) begin
                        head_q <= in_data;
                    end else if (in_fire) begin
                        skid_q  <= in_data;
                        state   <= SK_FULL;
                        ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state <= SK_EMPTY;
                    end
                end
                SK_FULL: begin
                    if (out_fire) begin
                        head_q  <= skid_q;
                        state   <= SK_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= SK_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // A capture while both slots are occupied would overwrite an entry
    no_capture_in_full: assert property (@(posedge clk) disable iff (rst)
        !((state == SK_FULL) && in_fire));

`else

    logic         valid_q;
    logic [W-1:0] data_q;

    // Single slot: it can refill in the same edge that MEM drains it
    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load on every ready cycle; an empty offer simply leaves the slot empty
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

`endif

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX->MEM pipeline boundary with forwarding; EX_MEM_SKID_EN selects 2-entry skid
module ex_mem_reg
    import riscv_uop_pkg::*;
#(
    parameter int XLEN    = UOP_XLEN,
    parameter int RADDR_W = UOP_RADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ex_valid,
    output logic                o_ex_ready,
    input  logic [XLEN-1:0]     i_alu_result,
    input  logic [XLEN-1:0]     i_store_data,
    input  logic [XLEN-1:0]     i_pc,
    input  logic [RADDR_W-1:0]  i_rd_addr,
    input  logic                i_rd_we,
    input  mem_op_t             i_mem_op,
    input  logic                i_flush,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output ex_mem_payload_t     o_mem_payload,
    output logic                o_fwd_valid,
    output logic [RADDR_W-1:0]  o_fwd_rd,
    output logic [XLEN-1:0]     o_fwd_data
);

    ex_mem_payload_t in_payload;
    ex_mem_payload_t head;

    // Pack the EX uop; x0 is hardwired so a write to it is dropped here
    always_comb begin
        in_payload            = '0;
        in_payload.alu_result = i_alu_result;
        in_payload.store_data = i_store_data;
        in_payload.pc         = i_pc;
        in_payload.rd_addr    = i_rd_addr;
        in_payload.rd_we      = i_rd_we & (i_rd_addr != '0);
        in_payload.mem_op     = i_mem_op;
    end

    pipe_skid_buf #(
        .W($bits(ex_mem_payload_t))
    ) u_buf (
        .clk      (i_clk),
        .rst      (i_rst),
        .flush    (i_flush),
        .in_valid (i_ex_valid),
        .in_ready (o_ex_ready),
        .in_data  (in_payload),
        .out_valid(o_mem_valid),
        .out_ready(i_mem_ready),
        .out_data (head)
    );

    assign o_mem_payload = head;

    // Load data is not known until MEM, so only ALU results are offered for bypass
    assign o_fwd_valid = o_mem_valid & head.rd_we & !is_load(head.mem_op);
    assign o_fwd_rd    = head.rd_addr;
    assign o_fwd_data  = head.alu_result;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - randomized bench for ex_mem_reg against a queue model
module tb_ex_mem_reg;
    import riscv_uop_pkg::*;

`ifdef EX_MEM_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_ex_valid;
    logic            o_ex_ready;
    logic [31:0]     i_alu_result;
    logic [31:0]     i_store_data;
    logic [31:0]     i_pc;
    logic [4:0]      i_rd_addr;
    logic            i_rd_we;
    mem_op_t         i_mem_op;
    logic            i_flush;
    logic            o_mem_valid;
    logic            i_mem_ready;
    ex_mem_payload_t o_mem_payload;
    logic            o_fwd_valid;
    logic [4:0]      o_fwd_rd;
    logic [31:0]     o_fwd_data;

    int              n_vec = 0;
    int              n_err = 0;
    ex_mem_payload_t model_q[$];
    logic [31:0]     seen[$];

    always #5 i_clk = ~i_clk;

    ex_mem_reg dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ex_valid   (i_ex_valid),
        .o_ex_ready   (o_ex_ready),
        .i_alu_result (i_alu_result),
        .i_store_data (i_store_data),
        .i_pc         (i_pc),
        .i_rd_addr    (i_rd_addr),
        .i_rd_we      (i_rd_we),
        .i_mem_op     (i_mem_op),
        .i_flush      (i_flush),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .o_mem_payload(o_mem_payload),
        .o_fwd_valid  (o_fwd_valid),
        .o_fwd_rd     (o_fwd_rd),
        .o_fwd_data   (o_fwd_data)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready();
        if (DEPTH == 2) return model_q.size() < 2;
        return (model_q.size() == 0) || i_mem_ready;
    endfunction

    function automatic bit model_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    task automatic drive(input bit v, input logic [31:0] alu, input logic [4:0] rd,
                         input bit we, input mem_op_t op);
        i_ex_valid   = v;
        i_alu_result = alu;
        i_store_data = alu ^ 32'h5A5A_A5A5;
        i_pc         = 32'h0000_4000 + {alu[15:0], 2'b00};
        i_rd_addr    = rd;
        i_rd_we      = we;
        i_mem_op     = op;
    endtask

    // One clock: check outputs at the falling edge, then advance the model
    task automatic cycle();
        bit              ry;
        ex_mem_payload_t p;
        @(negedge i_clk);
        ry = model_ready();
        chk("ex_ready", 128'(o_ex_ready), 128'(ry));
        chk("mem_valid", 128'(o_mem_valid), 128'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            chk("payload", 128'(o_mem_payload), 128'(model_q[0]));
            chk("fwd_valid", 128'(o_fwd_valid),
                128'(model_q[0].rd_we && !model_load(model_q[0].mem_op)));
            chk("fwd_rd", 128'(o_fwd_rd), 128'(model_q[0].rd_addr));
            chk("fwd_data", 128'(o_fwd_data), 128'(model_q[0].alu_result));
        end else begin
            chk("fwd_idle", 128'(o_fwd_valid), 128'(0));
        end
        if (o_mem_valid && i_mem_ready && !i_rst && !i_flush)
            seen.push_back(o_mem_payload.alu_result);
        @(posedge i_clk);
        if (i_rst || i_flush) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0 && i_mem_ready) void'(model_q.pop_front());
            if (i_ex_valid && ry) begin
                p.alu_result = i_alu_result;
                p.store_data = i_store_data;
                p.pc         = i_pc;
                p.rd_addr    = i_rd_addr;
                p.rd_we      = i_rd_we && (i_rd_addr != 5'd0);
                p.mem_op     = i_mem_op;
                model_q.push_back(p);
            end
        end
        #1;
    endtask

    task automatic rand_inputs();
        i_ex_valid   = 1'($urandom_range(0, 1));
        i_alu_result = $urandom;
        i_store_data = $urandom;
        i_pc         = $urandom;
        i_rd_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        i_rd_we      = 1'($urandom_range(0, 1));
        i_mem_op     = mem_op_t'($urandom_range(0, 8));
        i_mem_ready  = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        logic [31:0] abc[3];
        int          k;
        bit          ry;

        i_rst = 1'b1;
        i_flush = 1'b0;
        i_mem_ready = 1'b1;
        drive(1'b0, 32'd0, 5'd0, 1'b0, MEM_NONE);
        repeat (3) cycle();
        i_rst = 1'b0;

        // 1: traffic, then reset held 3 cycles mid-traffic
        repeat (10) begin rand_inputs(); cycle(); end
        i_rst = 1'b1;
        repeat (3) begin rand_inputs(); cycle(); end
        i_rst = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, MEM_NONE);
        i_mem_ready = 1'b1;
        cycle();
        chk("rst_valid", 128'(o_mem_valid), 128'(0));
        chk("rst_fwd", 128'(o_fwd_valid), 128'(0));
        chk("rst_payload", 128'(o_mem_payload), 128'(0));
        chk("rst_ready", 128'(o_ex_ready), 128'(1));

        // 2: ADD result 5 to x3
        drive(1'b1, 32'h0000_0005, 5'd3, 1'b1, MEM_NONE);
        cycle();
        drive(1'b0, 32'd0, 5'd0, 1'b0, MEM_NONE);
        chk("add_valid", 128'(o_mem_valid), 128'(1));
        chk("add_result", 128'(o_mem_payload.alu_result), 128'(32'h5));
        chk("add_fwd", {o_fwd_valid, o_fwd_rd, o_fwd_data}, {1'b1, 5'd3, 32'h5});
        cycle();

        // 3: write to x0 is suppressed
        drive(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, MEM_NONE);
        cycle();
        drive(1'b0, 32'd0, 5'd0, 1'b0, MEM_NONE);
        chk("x0_we", 128'(o_mem_payload.rd_we), 128'(0));
        chk("x0_fwd", 128'(o_fwd_valid), 128'(0));
        cycle();

        // 4: loads are not forwarded
        drive(1'b1, 32'h0000_1000, 5'd7, 1'b1, MEM_LW);
        cycle();
        drive(1'b0, 32'd0, 5'd0, 1'b0, MEM_NONE);
        chk("lw_valid", 128'(o_mem_valid), 128'(1));
        chk("lw_op", 128'(o_mem_payload.mem_op), 128'(MEM_LW));
        chk("lw_fwd", 128'(o_fwd_valid), 128'(0));
        cycle();

        // 5: MEM stalls 4 cycles while A, B, C are offered in order
        seen.delete();
        abc[0] = 32'hA;
        abc[1] = 32'hB;
        abc[2] = 32'hC;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            i_mem_ready = (c >= 4);
            if (k < 3) drive(1'b1, abc[k], 5'(k + 1), 1'b1, MEM_NONE);
            else drive(1'b0, 32'd0, 5'd0, 1'b0, MEM_NONE);
            ry = model_ready();
            cycle();
            if (i_ex_valid && ry) k++;
        end
        chk("order_cnt", 128'(seen.size()), 128'(3));
        for (int i = 0; i < 3; i++)
            chk("order", 128'((i < seen.size()) ? seen[i] : 32'hFFFF_FFFF), 128'(abc[i]));

        // 6: flush while full, with a new uop offered in the same cycle
        seen.delete();
        i_mem_ready = 1'b0;
        drive(1'b1, 32'h1111, 5'd4, 1'b1, MEM_NONE);
        cycle();
        drive(1'b1, 32'h2222, 5'd5, 1'b1, MEM_NONE);
        cycle();
        i_flush = 1'b1;
        drive(1'b1, 32'h3333, 5'd6, 1'b1, MEM_NONE);
        cycle();
        i_flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, MEM_NONE);
        i_mem_ready = 1'b1;
        chk("flush_valid", 128'(o_mem_valid), 128'(0));
        chk("flush_ready", 128'(o_ex_ready), 128'(1));
        repeat (4) cycle();
        chk("flush_leak", 128'(seen.size()), 128'(0));

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            i_flush = ($urandom_range(0, 39) == 0);
            i_rst   = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
